// File: rtl/tia_audio_gen_if.sv
// rtl/tia_audio_gen_if.sv - register write port of the TIA audio generator
interface tia_audio_gen_if;
    logic       wr_i;
    logic [2:0] ch_i;
    logic [1:0] sel_i;
    logic [7:0] dat_i;

    modport master (output wr_i, ch_i, sel_i, dat_i);
    modport slave  (input  wr_i, ch_i, sel_i, dat_i);
endinterface

// File: rtl/tia_audio_gen.sv
// rtl/tia_audio_gen.sv - 16-mode TIA sound generator with per-channel and mixed outputs
// Optional sigma-delta 1-bit DAC on pwm_o enabled by defining TIA_AUDIO_PWM_EN.
module tia_audio_gen #(
    parameter int NUM_CH   = 2,
    parameter int VOL_W    = 4,
    parameter int OUT_W    = 6,
    parameter int TICK_DIV = 114
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    tia_audio_gen_if.slave          bus,
    output logic                    tick_o,
    output logic [NUM_CH*VOL_W-1:0] ch_o,
    output logic [OUT_W-1:0]        mix_o,
    output logic                    pwm_o
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]    tick_cnt;
    logic [OUT_W-1:0] mix_sum;
    logic             unused_dat;

    assign unused_dat = ^bus.dat_i;
    assign tick_o     = enable_i && !rst_i && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt <= '0;
        end else if (enable_i) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [3:0]       audc;
        logic [4:0]       audf;
        logic [VOL_W-1:0] audv;
        logic [4:0]       fcnt;
        logic [6:0]       div;
        logic [3:0]       p4;
        logic [4:0]       p5;
        logic [8:0]       p9;
        logic             tone;
        logic [VOL_W-1:0] level;

        logic             wr_hit;
        logic             chclk;
        logic             frozen;
        logic             eff_tone;
        logic [3:0]       p4_step;
        logic [4:0]       p5_step;
        logic [8:0]       p9_step;
        logic [6:0]       div_lim;
        logic             div_used;
        logic             div_en;
        logic             div_wrap;
        logic [6:0]       div_nx;
        logic             p4_en;
        logic [3:0]       p4_nx;
        logic             tone_nx;

        assign wr_hit   = bus.wr_i && (int'(bus.ch_i) == n);
        assign chclk    = tick_o && (fcnt >= audf);
        assign frozen   = (audc == 4'd0) || (audc == 4'd11);
        assign eff_tone = frozen || tone;

        always_comb begin
            p4_step  = (p4 == '0) ? '1 : {p4[0] ^ p4[1], p4[3:1]};
            p5_step  = (p5 == '0) ? '1 : {p5[0] ^ p5[2], p5[4:1]};
            p9_step  = (p9 == '0) ? '1 : {p9[0] ^ p9[4], p9[8:1]};
            div_lim  = 7'd0;
            div_used = 1'b0;
            case (audc)
                4'd2:                 begin div_lim = 7'd14; div_used = 1'b1; end
                4'd6, 4'd10:          begin div_lim = 7'd30; div_used = 1'b1; end
                4'd12, 4'd13, 4'd15:  begin div_lim = 7'd2;  div_used = 1'b1; end
                4'd14:                begin div_lim = 7'd92; div_used = 1'b1; end
                default:              ;
            endcase
            // mode 15 gates its divide-by-3 with the poly5 output bit
            div_en   = div_used && ((audc != 4'd15) || p5[0]);
            div_wrap = div_en && (div >= div_lim);
            div_nx   = !div_en ? div : (div_wrap ? 7'd0 : div + 7'd1);
            case (audc)
                4'd1:    p4_en = 1'b1;
                4'd2:    p4_en = div_wrap;
                4'd3:    p4_en = p5[0];
                default: p4_en = 1'b0;
            endcase
            p4_nx = p4_en ? p4_step : p4;
            case (audc)
                4'd1, 4'd2, 4'd3:     tone_nx = p4_nx[0];
                4'd4, 4'd5:           tone_nx = ~tone;
                4'd6, 4'd10:          tone_nx = (div_nx < 7'd13);
                4'd7, 4'd9:           tone_nx = p5_step[0];
                4'd8:                 tone_nx = p9_step[0];
                4'd12, 4'd13, 4'd15:  tone_nx = div_wrap ? ~tone : tone;
                4'd14:                tone_nx = (div_nx < 7'd46);
                default:              tone_nx = 1'b1;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                audc  <= '0;
                audf  <= '0;
                audv  <= '0;
                fcnt  <= '0;
                div   <= '0;
                p4    <= '1;
                p5    <= '1;
                p9    <= '1;
                tone  <= 1'b0;
                level <= '0;
            end else begin
                if (wr_hit) begin
                    case (bus.sel_i)
                        2'd0:    audc <= bus.dat_i[3:0];
                        2'd1:    audf <= bus.dat_i[4:0];
                        2'd2:    audv <= bus.dat_i[VOL_W-1:0];
                        default: ;
                    endcase
                end
                if (tick_o) begin
                    fcnt <= (fcnt >= audf) ? 5'd0 : fcnt + 5'd1;
                end
                if (chclk) begin
                    if (frozen) begin
                        tone <= 1'b1;
                    end else begin
                        p4   <= p4_nx;
                        p5   <= p5_step;
                        p9   <= p9_step;
                        div  <= div_nx;
                        tone <= tone_nx;
                    end
                end
                level <= eff_tone ? audv : '0;
            end
        end

        assign ch_o[n*VOL_W +: VOL_W] = level;
    end

    always_comb begin
        mix_sum = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            mix_sum = mix_sum + OUT_W'(ch_o[n*VOL_W +: VOL_W]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mix_o <= '0;
        end else begin
            mix_o <= mix_sum;
        end
    end

`ifdef TIA_AUDIO_PWM_EN
    logic [OUT_W:0] acc;

    // carry out of the accumulator is the density-modulated bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[OUT_W-1:0]} + {1'b0, mix_o};
        end
    end

    assign pwm_o = acc[OUT_W];
`else
    assign pwm_o = 1'b0;
`endif
endmodule
